// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant owner and
// the all-ones byte-lane constant used for instruction fetches.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;
  // Wide enough for any DATA_W up to 1024; callers slice to DATA_W/8.
  localparam logic [127:0] BE_ALL = '1;
endpackage

// File: rtl/mem_wait_watchdog.sv
// Saturating stall counter; flags expiry on the stall cycle that brings the
// count to MAX_WAIT so the arbiter can abort on that same clock edge.
module mem_wait_watchdog #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        cnt <= '0;
    else if (clear)                    cnt <= '0;
    else if (count_en && cnt != LIMIT) cnt <= cnt + CW'(1);
  end

  generate
    if (MAX_WAIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = count_en && (cnt >= LIMIT - CW'(1));
    end
  endgenerate
endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-style memory port between the instruction and data ports
// of a Harvard core; all mem_* outputs are registered and held across stalls.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 0,
  parameter int MAX_WAIT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_ack,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_ack,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest,
  output logic                timeout_err
);
  localparam int BE_W = DATA_W / 8;

  state_t state, state_nx;
  grant_t last_grant, cur, pick;
  logic   ireq, dreq, do_grant, finish, expired;

  always_comb begin
    ireq     = i_read;
    dreq     = d_read | d_write;
    pick     = GNT_INSTR;
    // Data wins when alone, under fixed priority, or when instr went last.
    if (dreq && (!ireq || DATA_PRIO != 0 || last_grant == GNT_INSTR))
      pick = GNT_DATA;
    state_nx = state;
    do_grant = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:  if (ireq || dreq) begin do_grant = 1'b1; state_nx = GRANT; end
      GRANT: if (!mem_waitrequest || expired) begin finish = 1'b1; state_nx = RESP; end
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  mem_wait_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (do_grant),
    .count_en (state == GRANT && mem_waitrequest),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant     <= GNT_DATA;
      cur            <= GNT_INSTR;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      i_readdata     <= '0;
      d_readdata     <= '0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
      if (do_grant) begin
        cur        <= pick;
        last_grant <= pick;
        if (pick == GNT_DATA) begin
          mem_address    <= d_addr;
          mem_write      <= d_write;
          mem_read       <= !d_write;
          mem_byteenable <= d_byteenable;
          mem_writedata  <= d_writedata;
        end else begin
          mem_address    <= i_addr;
          mem_write      <= 1'b0;
          mem_read       <= 1'b1;
          mem_byteenable <= BE_ALL[BE_W-1:0];
          mem_writedata  <= '0;
        end
      end
      if (finish) begin
        mem_read    <= 1'b0;
        mem_write   <= 1'b0;
        // Still stalled here means the watchdog fired.
        timeout_err <= mem_waitrequest;
        if (cur == GNT_INSTR) i_ack <= 1'b1;
        else                  d_ack <= 1'b1;
        if (mem_read) begin
          if (cur == GNT_INSTR) i_readdata <= mem_waitrequest ? '0 : mem_readdata;
          else                  d_readdata <= mem_waitrequest ? '0 : mem_readdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: table of single transfers, a mid-grant reset,
// and round-robin / data-priority contention order on two instances.
module tb_mips_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] i_addr, d_addr, d_writedata;
  logic i_read, d_read, d_write, mem_waitrequest;
  logic [3:0] d_byteenable;

  logic [1:0][31:0] i_rd, d_rd, m_addr, m_wd, m_rdd;
  logic [1:0][3:0]  m_be;
  logic [1:0]       i_ak, d_ak, m_rd, m_wr, to;

  always #5 clk = ~clk;

  function automatic logic [31:0] mfun(logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24020005;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign m_rdd[k] = mfun(m_addr[k]);
    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(k), .MAX_WAIT(4)) u_dut (
      .clk(clk), .reset(reset),
      .i_addr(i_addr), .i_read(i_read), .i_readdata(i_rd[k]), .i_ack(i_ak[k]),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write),
      .d_byteenable(d_byteenable), .d_writedata(d_writedata),
      .d_readdata(d_rd[k]), .d_ack(d_ak[k]),
      .mem_address(m_addr[k]), .mem_read(m_rd[k]), .mem_write(m_wr[k]),
      .mem_byteenable(m_be[k]), .mem_writedata(m_wd[k]),
      .mem_readdata(m_rdd[k]), .mem_waitrequest(mem_waitrequest),
      .timeout_err(to[k])
    );
  end

  logic sel;
  int checks = 0, errors = 0, stall_left = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: sample on the falling edge, then drive the memory's stall.
  task automatic tick();
    @(negedge clk);
    if ((m_rd[sel] | m_wr[sel]) && stall_left > 0) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end else mem_waitrequest = 1'b0;
  endtask

  typedef struct {
    logic pd, wr, rdtoo;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
    int stall, lat, strobes;
    logic to;
  } vec_t;

  vec_t vt[8];
  vec_t v;
  logic [31:0] sbq[$];
  logic ordq[$];
  logic [31:0] exp_i, exp_d, val;

  task automatic contend(int phase);
    int got, ilow, dlow;
    logic [31:0] exp_rd;
    got = 0; ilow = 0; dlow = 0;
    i_addr = 32'h100; d_addr = 32'h200; d_byteenable = 4'hF;
    i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      chk($sformatf("p%0d_dual_ack", phase), {31'd0, i_ak[sel] & d_ak[sel]}, 32'd0);
      if (i_ak[sel]) begin
        got++;
        exp_rd = ordq.pop_front();
        chk($sformatf("p%0d_order%0d", phase, got), 32'd0, exp_rd);
        chk($sformatf("p%0d_i_rdata", phase), i_rd[sel], mfun(32'h100));
        i_read = 1'b0; ilow = 2;
      end else if (ilow > 0) begin
        ilow--;
        if (ilow == 0) i_read = 1'b1;
      end
      if (d_ak[sel]) begin
        got++;
        exp_rd = ordq.pop_front();
        chk($sformatf("p%0d_order%0d", phase, got), 32'd1, exp_rd);
        chk($sformatf("p%0d_d_rdata", phase), d_rd[sel], mfun(32'h200));
        d_read = 1'b0; dlow = 2;
      end else if (dlow > 0) begin
        dlow--;
        if (dlow == 0) d_read = 1'b1;
      end
    end
    chk($sformatf("p%0d_grants_seen", phase), got, 4);
    i_read = 1'b0; d_read = 1'b0;
    ordq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //       pd   wr   rdtoo addr           be    wdata          stall lat str to
    vt[0] = '{1'b0,1'b0,1'b0, 32'hBFC00000, 4'hF, 32'h0,         0,  2, 1, 1'b0};
    vt[1] = '{1'b1,1'b0,1'b0, 32'h00003000, 4'hF, 32'h0,         0,  2, 1, 1'b0};
    vt[2] = '{1'b1,1'b1,1'b0, 32'h00001000, 4'h3, 32'hDEADBEEF,  0,  2, 1, 1'b0};
    vt[3] = '{1'b1,1'b0,1'b0, 32'h00002000, 4'hF, 32'h0,         3,  5, 4, 1'b0};
    vt[4] = '{1'b0,1'b0,1'b0, 32'h00004000, 4'hF, 32'h0,        10,  5, 4, 1'b1};
    vt[5] = '{1'b0,1'b0,1'b0, 32'h00004004, 4'hF, 32'h0,         1,  3, 2, 1'b0};
    vt[6] = '{1'b1,1'b0,1'b0, 32'h00002004, 4'hF, 32'h0,        10,  5, 4, 1'b1};
    vt[7] = '{1'b1,1'b1,1'b1, 32'h00006000, 4'hC, 32'h12345678,  0,  2, 1, 1'b0};

    sel = 1'b0; reset = 1'b0; mem_waitrequest = 1'b0;
    i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_byteenable = '0; d_writedata = '0;
    exp_i = '0; exp_d = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_ctl", k), {27'd0, m_rd[k], m_wr[k], i_ak[k], d_ak[k], to[k]}, 32'd0);
      chk($sformatf("rst%0d_addr", k), m_addr[k], 32'd0);
      chk($sformatf("rst%0d_be_wd", k), m_wd[k] | {28'd0, m_be[k]}, 32'd0);
      chk($sformatf("rst%0d_rdata", k), i_rd[k] | d_rd[k], 32'd0);
    end
    tick(); tick();
    reset = 1'b1;
    tick();

    foreach (vt[n]) begin
      int lat, strobes;
      bit done;
      v = vt[n];
      stall_left = v.stall;
      i_read = !v.pd;
      d_read = v.pd && (!v.wr || v.rdtoo);
      d_write = v.pd && v.wr;
      i_addr = v.addr; d_addr = v.addr;
      d_byteenable = v.be; d_writedata = v.wdata;
      val = v.to ? 32'd0 : mfun(v.addr);
      if (!v.pd) exp_i = val;
      else if (!v.wr) exp_d = val;
      sbq.push_back(v.pd ? exp_d : exp_i);
      lat = 0; strobes = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        tick();
        lat++;
        chk($sformatf("v%0d_other_ack", n), {31'd0, v.pd ? i_ak[0] : d_ak[0]}, 32'd0);
        if (m_rd[0] | m_wr[0]) begin
          strobes++;
          chk($sformatf("v%0d_mem_addr", n), m_addr[0], v.addr);
          chk($sformatf("v%0d_mem_rw", n), {30'd0, m_rd[0], m_wr[0]}, {30'd0, !v.wr, v.wr});
          chk($sformatf("v%0d_mem_be", n), {28'd0, m_be[0]}, {28'd0, v.pd ? v.be : 4'hF});
          if (v.wr) chk($sformatf("v%0d_mem_wd", n), m_wd[0], v.wdata);
        end
        if (v.pd ? d_ak[0] : i_ak[0]) begin
          done = 1;
          chk($sformatf("v%0d_latency", n), lat, v.lat);
          chk($sformatf("v%0d_strobe_cycles", n), strobes, v.strobes);
          chk($sformatf("v%0d_timeout_err", n), {31'd0, to[0]}, {31'd0, v.to});
          chk($sformatf("v%0d_rdata", n), v.pd ? d_rd[0] : i_rd[0], sbq.pop_front());
        end
      end
      if (!done) chk($sformatf("v%0d_ack_seen", n), 32'd0, 32'd1);
      i_read = 0; d_read = 0; d_write = 0;
      tick(); tick();
    end

    // Reset while a write is stalled: strobe must fall without a clock edge.
    d_write = 1'b1; d_addr = 32'h5000; d_byteenable = 4'hF; d_writedata = 32'hCAFE;
    stall_left = 10;
    tick(); tick();
    chk("rstmid_write_before", {31'd0, m_wr[0]}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("rstmid_write_async", {30'd0, m_wr[0], m_rd[0]}, 32'd0);
    d_write = 1'b0; stall_left = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rstmid_no_ack", {30'd0, i_ak[0], d_ak[0]}, 32'd0);
    end
    reset = 1'b1;
    tick();
    chk("rstmid_no_ack_after", {29'd0, i_ak[0], d_ak[0], to[0]}, 32'd0);

    ordq = '{1'b0, 1'b1, 1'b0, 1'b1};
    contend(0);

    reset = 1'b0;
    tick();
    reset = 1'b1; sel = 1'b1;
    tick();
    ordq = '{1'b1, 1'b0, 1'b1, 1'b0};
    contend(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one Avalon-style memory port between the CPU's instruction-fetch port and data port, so the Harvard core can run against a single unified memory.
- Holds each granted request stable across mem_waitrequest stalls and returns registered read data with a one-cycle ack pulse.
- Arbitrates round-robin or with fixed data priority.
- Includes a watchdog that aborts a stalled transfer.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DATA_PRIO, 0, 0 = round-robin between ports; 1 = data port always wins contention.
- MAX_WAIT, 64, waitrequest cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_addr  in  ADDR_W  instruction fetch address.
- i_read  in  1  fetch request; level, held until i_ack.
- i_readdata  out  DATA_W  fetched word; valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_addr  in  ADDR_W  data address.
- d_read  in  1  data read request; level, held until d_ack.
- d_write  in  1  data write request; level, held until d_ack.
- d_byteenable  in  DATA_W/8  write/read byte lanes.
- d_writedata  in  DATA_W  store data.
- d_readdata  out  DATA_W  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_address  out  ADDR_W  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byteenable  out  DATA_W/8  memory byte lanes.
- mem_writedata  out  DATA_W  memory write data.
- mem_readdata  in  DATA_W  memory read data; valid when the strobe is high and waitrequest is low.
- mem_waitrequest  in  1  memory stall.
- timeout_err  out  1  pulses with the ack of an aborted transfer.

Behaviour:
- Reset (reset=0, immediate):
  - state=IDLE; last_grant=DATA.
  - mem_read, mem_write, mem_byteenable, mem_address and mem_writedata = 0.
  - i_ack, d_ack and timeout_err = 0.
  - i_readdata and d_readdata = 0.
  - Wait counter = 0.
  - Reset mid-transfer drops the strobes at once; there is no ack and no completion.
- FSM states: IDLE, GRANT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - Pending requests are ireq=i_read and dreq=d_read|d_write.
  - Only one pending: grant it.
  - Both pending with DATA_PRIO=1: grant data.
  - Both pending with DATA_PRIO=0: grant the port that is not last_grant.
  - On grant: latch the address, direction, byteenable and writedata into the mem_* output registers; set the strobe; go to GRANT; update last_grant.
  - Instruction grants drive byteenable all-ones and write=0.
  - d_read and d_write both high: treated as a write.
- GRANT:
  - mem_* outputs are held constant while mem_waitrequest=1.
  - On the first cycle with mem_waitrequest=0: capture mem_readdata (reads only) into the granted port's readdata register; drop the strobe; go to RESP.
- RESP:
  - Assert the granted port's ack for exactly one cycle, then go to IDLE.
  - The requester must drop or change its request in the cycle after the ack.
  - A new request is sampled in the following IDLE cycle.
  - Minimum latency is request to ack in 2 cycles; peak throughput is 1 transfer per 3 cycles.
- readdata registers hold their value until the next completion for the same port. A write completion leaves d_readdata unchanged.
- Watchdog:
  - The counter increments each GRANT cycle with waitrequest=1 and clears on entry to GRANT.
  - When MAX_WAIT≠0 and the count reaches MAX_WAIT: drop the strobe, go to RESP, and assert ack together with timeout_err.
  - On a timed-out read, that port's readdata is 0.
- Width rules: the counter is $clog2(MAX_WAIT+1) bits and saturates, never wrapping. No address translation is performed.
- Simultaneous ack and a new request on the other port: the new request is arbitrated in the next IDLE.
- No combinational path from mem_waitrequest to mem_* outputs.

Decomposition:
- Package mips_mem_pkg:
  - state enum {IDLE, GRANT, RESP}.
  - grant enum {GNT_INSTR, GNT_DATA}.
  - Constant BE_ALL for the all-ones byteenable.
- Sub-module mem_wait_watchdog:
  - Parameterised by MAX_WAIT.
  - Inputs: clk, reset, clear, count_en.
  - Output: expired.

Test Plan:
- Single fetch: i_read=1, i_addr=0xBFC00000, waitrequest=0, memory returns 0x24020005 → mem_read is high for 1 cycle at that address; i_ack pulses 2 cycles after the request with i_readdata=0x24020005; d_ack stays 0.
- Data write: d_write=1, d_addr=0x1000, d_byteenable=4'b0011, d_writedata=0xDEADBEEF → one mem_write cycle with the same address, lanes and data; d_ack pulses; d_readdata is unchanged.
- Contention with DATA_PRIO=0: from reset, i_read and d_read held continuously → grants go I, D, I, D. With DATA_PRIO=1, the same stimulus produces the order D, I, D, I.
- Stall: waitrequest=1 for 3 cycles on a read of 0x2000 → mem_address, mem_read and mem_byteenable are constant for 4 cycles; ack follows the release; readdata matches the value sampled on the release cycle.
- Timeout with MAX_WAIT=4: waitrequest held high → strobe drops after 4 stall cycles; ack and timeout_err pulse together; readdata=0; the next request is served normally.
- Reset mid-GRANT: reset=0 during a stalled write → mem_write=0 in the same cycle without a clock edge; no ack; after release the first contention grants the instruction port.
